// File: rtl/alumux.sv
// ============================================================================
// alumux : ALU operand select encodings.
// Revision: 1.0
// ============================================================================
`default_nettype none

package alumux;
    typedef enum logic {
        rs1_out = 1'b0,
        pc_out  = 1'b1
    } alumux1_sel_t;

    typedef enum logic [2:0] {
        i_imm   = 3'b000,
        u_imm   = 3'b001,
        b_imm   = 3'b010,
        s_imm   = 3'b011,
        j_imm   = 3'b100,
        rs2_out = 3'b101
    } alumux2_sel_t;
endpackage : alumux

`default_nettype wire

// File: rtl/cmpmux.sv
// ============================================================================
// cmpmux : comparator second operand select encoding.
// Revision: 1.0
// ============================================================================
`default_nettype none

package cmpmux;
    typedef enum logic {
        rs2_out = 1'b0,
        i_imm   = 1'b1
    } cmpmux_sel_t;
endpackage : cmpmux

`default_nettype wire

// File: rtl/marmux.sv
// ============================================================================
// marmux : memory address register input select encoding.
// Revision: 1.0
// ============================================================================
`default_nettype none

package marmux;
    typedef enum logic {
        pc_out  = 1'b0,
        alu_out = 1'b1
    } marmux_sel_t;
endpackage : marmux

`default_nettype wire

// File: rtl/pcmux.sv
// ============================================================================
// pcmux : PC input select encoding.
// Revision: 1.0
// ============================================================================
`default_nettype none

package pcmux;
    typedef enum logic [1:0] {
        pc_plus4 = 2'b00,
        alu_out  = 2'b01,
        alu_mod2 = 2'b10
    } pcmux_sel_t;
endpackage : pcmux

`default_nettype wire

// File: rtl/regfilemux.sv
// ============================================================================
// regfilemux : register file write-data select encoding.
// Revision: 1.0
// ============================================================================
`default_nettype none

package regfilemux;
    typedef enum logic [3:0] {
        alu_out  = 4'd0,
        br_en    = 4'd1,
        u_imm    = 4'd2,
        lw       = 4'd3,
        pc_plus4 = 4'd4,
        lb       = 4'd5,
        lbu      = 4'd6,
        lh       = 4'd7,
        lhu      = 4'd8
    } regfilemux_sel_t;
endpackage : regfilemux

`default_nettype wire

// File: rtl/rv32i_types.sv
// ============================================================================
// rv32i_types : RV32I opcode/funct3 encodings, ALU ops and control FSM states.
// Revision: 1.0
// ============================================================================
`default_nettype none

package rv32i_types;
    typedef enum logic [6:0] {
        op_lui   = 7'b0110111,
        op_auipc = 7'b0010111,
        op_jal   = 7'b1101111,
        op_jalr  = 7'b1100111,
        op_br    = 7'b1100011,
        op_load  = 7'b0000011,
        op_store = 7'b0100011,
        op_imm   = 7'b0010011,
        op_reg   = 7'b0110011,
        op_csr   = 7'b1110011
    } rv32i_opcode;

    typedef enum logic [2:0] {
        beq  = 3'b000,
        bne  = 3'b001,
        blt  = 3'b100,
        bge  = 3'b101,
        bltu = 3'b110,
        bgeu = 3'b111
    } branch_funct3_t;

    typedef enum logic [2:0] {
        lb  = 3'b000,
        lh  = 3'b001,
        lw  = 3'b010,
        lbu = 3'b100,
        lhu = 3'b101
    } load_funct3_t;

    typedef enum logic [2:0] {
        sb = 3'b000,
        sh = 3'b001,
        sw = 3'b010
    } store_funct3_t;

    typedef enum logic [2:0] {
        add  = 3'b000,
        sll  = 3'b001,
        slt  = 3'b010,
        sltu = 3'b011,
        axor = 3'b100,
        sr   = 3'b101,
        aor  = 3'b110,
        aand = 3'b111
    } arith_funct3_t;

    typedef enum logic [2:0] {
        alu_add = 3'b000,
        alu_sll = 3'b001,
        alu_sra = 3'b010,
        alu_sub = 3'b011,
        alu_xor = 3'b100,
        alu_srl = 3'b101,
        alu_or  = 3'b110,
        alu_and = 3'b111
    } alu_ops;

    typedef enum logic [3:0] {
        FETCH1, FETCH2, FETCH3, DECODE,
        IMM, REG, LUI, AUIPC,
        BR, JAL, JALR, CALC_ADDR,
        LD1, LD2, ST1, ST2
    } mc_state_t;
endpackage : rv32i_types

`default_nettype wire

// File: rtl/mc_control.sv
// ============================================================================
// mc_control : multicycle RV32I control unit (Moore FSM driving datapath).
// Revision: 1.0
// ============================================================================
`default_nettype none

module mc_control
    import rv32i_types::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic [6:0]                  opcode,
    input  logic [2:0]                  funct3,
    input  logic [6:0]                  funct7,
    input  logic                        br_en,
    input  logic [1:0]                  addr_lo,
    input  logic                        mem_resp,
    output logic                        load_pc,
    output logic                        load_ir,
    output logic                        load_regfile,
    output logic                        load_mar,
    output logic                        load_mdr,
    output logic                        load_data_out,
    output pcmux::pcmux_sel_t           pcmux_sel,
    output alumux::alumux1_sel_t        alumux1_sel,
    output alumux::alumux2_sel_t        alumux2_sel,
    output regfilemux::regfilemux_sel_t regfilemux_sel,
    output marmux::marmux_sel_t         marmux_sel,
    output cmpmux::cmpmux_sel_t         cmpmux_sel,
    output alu_ops                      aluop,
    output branch_funct3_t              cmpop,
    output logic                        mem_read,
    output logic                        mem_write,
    output logic [3:0]                  mem_byte_enable
);

    mc_state_t state_q, state_d;

    logic w_unused_funct7;
    assign w_unused_funct7 = ^{funct7[6], funct7[4:0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= FETCH1;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH1: state_d = FETCH2;
            FETCH2: if (mem_resp) state_d = FETCH3;
            FETCH3: state_d = DECODE;
            DECODE: begin
                case (opcode)
                    op_imm:   state_d = IMM;
                    op_reg:   state_d = REG;
                    op_lui:   state_d = LUI;
                    op_auipc: state_d = AUIPC;
                    op_br:    state_d = BR;
                    op_jal:   state_d = JAL;
                    op_jalr:  state_d = JALR;
                    op_load,
                    op_store: state_d = CALC_ADDR;
                    default:  state_d = FETCH1;
                endcase
            end
            CALC_ADDR: state_d = (opcode == op_store) ? ST1 : LD1;
            LD1:       if (mem_resp) state_d = LD2;
            ST1:       if (mem_resp) state_d = ST2;
            default:   state_d = FETCH1;
        endcase
    end

    always_comb begin
        load_pc         = 1'b0;
        load_ir         = 1'b0;
        load_regfile    = 1'b0;
        load_mar        = 1'b0;
        load_mdr        = 1'b0;
        load_data_out   = 1'b0;
        pcmux_sel       = pcmux::pc_plus4;
        alumux1_sel     = alumux::rs1_out;
        alumux2_sel     = alumux::i_imm;
        regfilemux_sel  = regfilemux::alu_out;
        marmux_sel      = marmux::pc_out;
        cmpmux_sel      = cmpmux::rs2_out;
        aluop           = alu_add;
        cmpop           = branch_funct3_t'(funct3);
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_byte_enable = 4'b1111;

        // Reset masks the FETCH1 decode so a held strobe drops with rst.
        if (rst) begin
            case (state_q)
                FETCH1: load_mar = 1'b1;
                FETCH2: begin
                    mem_read = 1'b1;
                    load_mdr = 1'b1;
                end
                FETCH3: load_ir = 1'b1;
                IMM: begin
                    load_regfile = 1'b1;
                    load_pc      = 1'b1;
                    case (funct3)
                        slt: begin
                            cmpop          = blt;
                            cmpmux_sel     = cmpmux::i_imm;
                            regfilemux_sel = regfilemux::br_en;
                        end
                        sltu: begin
                            cmpop          = bltu;
                            cmpmux_sel     = cmpmux::i_imm;
                            regfilemux_sel = regfilemux::br_en;
                        end
                        sr:      aluop = funct7[5] ? alu_sra : alu_srl;
                        default: aluop = alu_ops'(funct3);
                    endcase
                end
                REG: begin
                    load_regfile = 1'b1;
                    load_pc      = 1'b1;
                    alumux2_sel  = alumux::rs2_out;
                    case (funct3)
                        add: aluop = funct7[5] ? alu_sub : alu_add;
                        sr:  aluop = funct7[5] ? alu_sra : alu_srl;
                        slt: begin
                            cmpop          = blt;
                            regfilemux_sel = regfilemux::br_en;
                        end
                        sltu: begin
                            cmpop          = bltu;
                            regfilemux_sel = regfilemux::br_en;
                        end
                        default: aluop = alu_ops'(funct3);
                    endcase
                end
                LUI: begin
                    load_regfile   = 1'b1;
                    load_pc        = 1'b1;
                    regfilemux_sel = regfilemux::u_imm;
                end
                AUIPC: begin
                    load_regfile = 1'b1;
                    load_pc      = 1'b1;
                    alumux1_sel  = alumux::pc_out;
                    alumux2_sel  = alumux::u_imm;
                end
                BR: begin
                    load_pc     = 1'b1;
                    alumux1_sel = alumux::pc_out;
                    alumux2_sel = alumux::b_imm;
                    pcmux_sel   = br_en ? pcmux::alu_out : pcmux::pc_plus4;
                end
                JAL: begin
                    load_regfile   = 1'b1;
                    load_pc        = 1'b1;
                    regfilemux_sel = regfilemux::pc_plus4;
                    alumux1_sel    = alumux::pc_out;
                    alumux2_sel    = alumux::j_imm;
                    pcmux_sel      = pcmux::alu_out;
                end
                JALR: begin
                    load_regfile   = 1'b1;
                    load_pc        = 1'b1;
                    regfilemux_sel = regfilemux::pc_plus4;
                    pcmux_sel      = pcmux::alu_mod2;
                end
                CALC_ADDR: begin
                    load_mar   = 1'b1;
                    marmux_sel = marmux::alu_out;
                    if (opcode == op_store) begin
                        alumux2_sel   = alumux::s_imm;
                        load_data_out = 1'b1;
                    end
                end
                LD1: begin
                    mem_read = 1'b1;
                    load_mdr = 1'b1;
                end
                LD2: begin
                    load_regfile = 1'b1;
                    load_pc      = 1'b1;
                    case (funct3)
                        lb:      regfilemux_sel = regfilemux::lb;
                        lh:      regfilemux_sel = regfilemux::lh;
                        lbu:     regfilemux_sel = regfilemux::lbu;
                        lhu:     regfilemux_sel = regfilemux::lhu;
                        default: regfilemux_sel = regfilemux::lw;
                    endcase
                end
                ST1: begin
                    mem_write   = 1'b1;
                    alumux2_sel = alumux::s_imm;
                    // Misaligned sh simply loses the bits shifted past lane 3.
                    case (funct3)
                        sb:      mem_byte_enable = 4'b0001 << addr_lo;
                        sh:      mem_byte_enable = 4'b0011 << addr_lo;
                        default: mem_byte_enable = 4'b1111;
                    endcase
                end
                ST2: load_pc = 1'b1;
                default: ;
            endcase
        end
    end

endmodule : mc_control

`default_nettype wire

// File: tb/tb_mc_control.sv
// ============================================================================
// tb_mc_control : directed vector bench for the multicycle control FSM.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mc_control;
    import rv32i_types::*;

    typedef struct packed {
        logic [5:0] loads;      // pc, ir, regfile, mar, mdr, data_out
        logic [1:0] pcm;
        logic       a1;
        logic [2:0] a2;
        logic [3:0] rfm;
        logic       mm;
        logic       cm;
        logic [2:0] alu;
        logic [2:0] cmp;
        logic       rd;
        logic       wr;
        logic [3:0] mbe;
    } ctl_t;

    typedef struct {
        string      name;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic       br;
        ctl_t       exp;
    } vec_t;

    localparam logic [5:0] L_PC   = 6'b100000;
    localparam logic [5:0] L_IR   = 6'b010000;
    localparam logic [5:0] L_RF   = 6'b001000;
    localparam logic [5:0] L_MAR  = 6'b000100;
    localparam logic [5:0] L_MDR  = 6'b000010;
    localparam logic [5:0] L_DOUT = 6'b000001;

    logic clk = 1'b0;
    logic rst;
    logic [6:0] opcode, funct7;
    logic [2:0] funct3;
    logic br_en, mem_resp;
    logic [1:0] addr_lo;
    logic load_pc, load_ir, load_regfile, load_mar, load_mdr, load_data_out;
    pcmux::pcmux_sel_t           pcmux_sel;
    alumux::alumux1_sel_t        alumux1_sel;
    alumux::alumux2_sel_t        alumux2_sel;
    regfilemux::regfilemux_sel_t regfilemux_sel;
    marmux::marmux_sel_t         marmux_sel;
    cmpmux::cmpmux_sel_t         cmpmux_sel;
    alu_ops                      aluop;
    branch_funct3_t              cmpop;
    logic mem_read, mem_write;
    logic [3:0] mem_byte_enable;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mc_control dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .br_en(br_en), .addr_lo(addr_lo), .mem_resp(mem_resp),
        .load_pc(load_pc), .load_ir(load_ir), .load_regfile(load_regfile),
        .load_mar(load_mar), .load_mdr(load_mdr), .load_data_out(load_data_out),
        .pcmux_sel(pcmux_sel), .alumux1_sel(alumux1_sel), .alumux2_sel(alumux2_sel),
        .regfilemux_sel(regfilemux_sel), .marmux_sel(marmux_sel), .cmpmux_sel(cmpmux_sel),
        .aluop(aluop), .cmpop(cmpop), .mem_read(mem_read), .mem_write(mem_write),
        .mem_byte_enable(mem_byte_enable)
    );

    ctl_t actual;
    assign actual = {load_pc, load_ir, load_regfile, load_mar, load_mdr, load_data_out,
                     pcmux_sel, alumux1_sel, alumux2_sel, regfilemux_sel, marmux_sel,
                     cmpmux_sel, aluop, cmpop, mem_read, mem_write, mem_byte_enable};

    function automatic ctl_t dflt(input logic [2:0] f3);
        ctl_t c;
        c.loads = 6'b0;
        c.pcm   = pcmux::pc_plus4;
        c.a1    = alumux::rs1_out;
        c.a2    = alumux::i_imm;
        c.rfm   = regfilemux::alu_out;
        c.mm    = marmux::pc_out;
        c.cm    = cmpmux::rs2_out;
        c.alu   = alu_add;
        c.cmp   = f3;
        c.rd    = 1'b0;
        c.wr    = 1'b0;
        c.mbe   = 4'b1111;
        return c;
    endfunction

    function automatic vec_t v(input string nm, input logic [6:0] op, input logic [2:0] f3,
                               input logic [6:0] f7, input logic br, input logic [5:0] ld);
        vec_t r;
        r.name = nm; r.op = op; r.f3 = f3; r.f7 = f7; r.br = br;
        r.exp = dflt(f3);
        r.exp.loads = ld;
        return r;
    endfunction

    task automatic check(input string nm, input ctl_t exp);
        n_chk++;
        if (actual !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, actual, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered just after the edge that puts the FSM in FETCH1; returns in the execute state.
    task automatic fetch(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input int waits);
        ctl_t e;
        opcode = op; funct3 = f3; funct7 = f7; mem_resp = 1'b0;
        #1;
        e = dflt(f3); e.loads = L_MAR;
        check("fetch1", e);
        tick();
        e = dflt(f3); e.loads = L_MDR; e.rd = 1'b1;
        for (int i = 0; i <= waits; i++) begin
            mem_resp = (i == waits);
            #1;
            check("fetch2", e);
            tick();
        end
        mem_resp = 1'b0;
        #1;
        e = dflt(f3); e.loads = L_IR;
        check("fetch3", e);
        tick();
        #1;
        check("decode", dflt(f3));
        tick();
    endtask

    vec_t tbl[19];
    ctl_t e;
    logic [3:0] sh_masks [4];

    initial begin
        tbl[0]  = v("addi",  op_imm, 3'b000, 7'h00, 1'b0, L_RF | L_PC);
        tbl[1]  = v("slti",  op_imm, 3'b010, 7'h00, 1'b0, L_RF | L_PC);
        tbl[1].exp.cm = cmpmux::i_imm; tbl[1].exp.rfm = regfilemux::br_en; tbl[1].exp.cmp = blt;
        tbl[2]  = v("sltiu", op_imm, 3'b011, 7'h00, 1'b0, L_RF | L_PC);
        tbl[2].exp.cm = cmpmux::i_imm; tbl[2].exp.rfm = regfilemux::br_en; tbl[2].exp.cmp = bltu;
        tbl[3]  = v("srai",  op_imm, 3'b101, 7'h20, 1'b0, L_RF | L_PC);
        tbl[3].exp.alu = alu_sra;
        tbl[4]  = v("srli",  op_imm, 3'b101, 7'h00, 1'b0, L_RF | L_PC);
        tbl[4].exp.alu = alu_srl;
        tbl[5]  = v("xori",  op_imm, 3'b100, 7'h00, 1'b0, L_RF | L_PC);
        tbl[5].exp.alu = alu_xor;
        tbl[6]  = v("andi",  op_imm, 3'b111, 7'h00, 1'b0, L_RF | L_PC);
        tbl[6].exp.alu = alu_and;
        tbl[7]  = v("add",   op_reg, 3'b000, 7'h00, 1'b0, L_RF | L_PC);
        tbl[7].exp.a2 = alumux::rs2_out;
        tbl[8]  = v("sub",   op_reg, 3'b000, 7'h20, 1'b0, L_RF | L_PC);
        tbl[8].exp.a2 = alumux::rs2_out; tbl[8].exp.alu = alu_sub;
        tbl[9]  = v("sra",   op_reg, 3'b101, 7'h20, 1'b0, L_RF | L_PC);
        tbl[9].exp.a2 = alumux::rs2_out; tbl[9].exp.alu = alu_sra;
        tbl[10] = v("srl",   op_reg, 3'b101, 7'h00, 1'b0, L_RF | L_PC);
        tbl[10].exp.a2 = alumux::rs2_out; tbl[10].exp.alu = alu_srl;
        tbl[11] = v("slt",   op_reg, 3'b010, 7'h00, 1'b0, L_RF | L_PC);
        tbl[11].exp.a2 = alumux::rs2_out; tbl[11].exp.rfm = regfilemux::br_en; tbl[11].exp.cmp = blt;
        tbl[12] = v("sll",   op_reg, 3'b001, 7'h00, 1'b0, L_RF | L_PC);
        tbl[12].exp.a2 = alumux::rs2_out; tbl[12].exp.alu = alu_sll;
        tbl[13] = v("lui",   op_lui, 3'b000, 7'h00, 1'b0, L_RF | L_PC);
        tbl[13].exp.rfm = regfilemux::u_imm;
        tbl[14] = v("auipc", op_auipc, 3'b000, 7'h00, 1'b0, L_RF | L_PC);
        tbl[14].exp.a1 = alumux::pc_out; tbl[14].exp.a2 = alumux::u_imm;
        tbl[15] = v("beq_taken", op_br, 3'b000, 7'h00, 1'b1, L_PC);
        tbl[15].exp.a1 = alumux::pc_out; tbl[15].exp.a2 = alumux::b_imm; tbl[15].exp.pcm = pcmux::alu_out;
        tbl[16] = v("bne_not_taken", op_br, 3'b001, 7'h00, 1'b0, L_PC);
        tbl[16].exp.a1 = alumux::pc_out; tbl[16].exp.a2 = alumux::b_imm;
        tbl[17] = v("jal",   op_jal, 3'b000, 7'h00, 1'b0, L_RF | L_PC);
        tbl[17].exp.rfm = regfilemux::pc_plus4; tbl[17].exp.a1 = alumux::pc_out;
        tbl[17].exp.a2 = alumux::j_imm; tbl[17].exp.pcm = pcmux::alu_out;
        tbl[18] = v("jalr",  op_jalr, 3'b000, 7'h00, 1'b0, L_RF | L_PC);
        tbl[18].exp.rfm = regfilemux::pc_plus4; tbl[18].exp.pcm = pcmux::alu_mod2;
        sh_masks[0] = 4'b0011; sh_masks[1] = 4'b0110; sh_masks[2] = 4'b1100; sh_masks[3] = 4'b1000;

        rst = 1'b0; opcode = 7'h0; funct3 = 3'b000; funct7 = 7'h0;
        br_en = 1'b0; addr_lo = 2'b00; mem_resp = 1'b0;
        #2;
        check("reset_defaults", dflt(3'b000));
        tick();
        rst = 1'b1;

        // addi with three wait states before the fetch response
        fetch(op_imm, 3'b000, 7'h00, 3);
        #1;
        check("addi_wait_imm", tbl[0].exp);
        tick();

        for (int i = 0; i < 19; i++) begin
            fetch(tbl[i].op, tbl[i].f3, tbl[i].f7, 0);
            br_en = tbl[i].br;
            #1;
            check(tbl[i].name, tbl[i].exp);
            tick();
            br_en = 1'b0;
        end

        // sb to 0x103: lane 3 only, held through two wait states
        fetch(op_store, 3'b000, 7'h00, 1);
        addr_lo = 2'b11;
        #1;
        e = dflt(3'b000); e.loads = L_MAR | L_DOUT; e.mm = marmux::alu_out; e.a2 = alumux::s_imm;
        check("sb_calc_addr", e);
        tick();
        e = dflt(3'b000); e.wr = 1'b1; e.a2 = alumux::s_imm; e.mbe = 4'b1000;
        for (int i = 0; i < 3; i++) begin
            mem_resp = (i == 2);
            #1;
            check("sb_st1", e);
            tick();
        end
        mem_resp = 1'b0;
        #1;
        e = dflt(3'b000); e.loads = L_PC;
        check("sb_st2", e);
        tick();

        // sh masks for every byte offset, including the truncated 2'b11 case
        fetch(op_store, 3'b001, 7'h00, 0);
        tick();
        for (int i = 0; i < 4; i++) begin
            addr_lo = 2'(i);
            #1;
            e = dflt(3'b001); e.wr = 1'b1; e.a2 = alumux::s_imm; e.mbe = sh_masks[i];
            check("sh_mask", e);
        end
        mem_resp = 1'b1;
        tick();
        mem_resp = 1'b0;
        tick();

        // lhu from 0x102; a stray response during CALC_ADDR must not skip LD1
        fetch(op_load, 3'b101, 7'h00, 0);
        addr_lo = 2'b10;
        mem_resp = 1'b1;
        #1;
        e = dflt(3'b101); e.loads = L_MAR; e.mm = marmux::alu_out;
        check("lhu_calc_addr", e);
        tick();
        e = dflt(3'b101); e.loads = L_MDR; e.rd = 1'b1;
        for (int i = 0; i < 3; i++) begin
            mem_resp = (i == 2);
            #1;
            check("lhu_ld1", e);
            tick();
        end
        mem_resp = 1'b0;
        #1;
        e = dflt(3'b101); e.loads = L_RF | L_PC; e.rfm = regfilemux::lhu;
        check("lhu_ld2", e);
        tick();

        // unknown opcode returns to FETCH1 without touching PC or regfile
        fetch(7'b0000000, 3'b000, 7'h00, 0);
        #1;
        e = dflt(3'b000); e.loads = L_MAR;
        check("unknown_op_fetch1", e);
        tick();
        e = dflt(3'b000); e.loads = L_MDR; e.rd = 1'b1;
        check("unknown_op_fetch2", e);
        rst = 1'b0;
        #1;
        rst = 1'b1;

        // asynchronous reset while LD1 is holding mem_read
        fetch(op_load, 3'b010, 7'h00, 0);
        tick();
        #1;
        e = dflt(3'b010); e.loads = L_MDR; e.rd = 1'b1;
        check("lw_ld1_before_reset", e);
        rst = 1'b0;
        #1;
        check("reset_drops_mem_read", dflt(3'b010));
        tick();
        check("reset_held", dflt(3'b010));
        rst = 1'b1;
        #1;
        e = dflt(3'b010); e.loads = L_MAR;
        check("post_reset_fetch1", e);
        tick();
        e = dflt(3'b010); e.loads = L_MDR; e.rd = 1'b1;
        check("post_reset_fetch2", e);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end of test");
        $fatal(1, "watchdog");
    end

endmodule : tb_mc_control

`default_nettype wire

// File: doc/mc_control.md
MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 rst  in  1  asynchronous, active-low reset.
REQ-003 opcode  in  7  rv32i_opcode from IR.
REQ-004 funct3  in  3  IR funct3.
REQ-005 funct7  in  7  IR funct7; bit 5 selects sub/sra.
REQ-006 br_en  in  1  CMP result.
REQ-007 addr_lo  in  2  alu_out[1:0], byte offset of load/store address.
REQ-008 mem_resp  in  1  memory completion pulse, one cycle.
REQ-009 load_pc, load_ir, load_regfile, load_mar, load_mdr, load_data_out  out  1 each  register enables.
REQ-010 pcmux_sel, alumux1_sel, alumux2_sel, regfilemux_sel, marmux_sel, cmpmux_sel  out  enum  datapath mux selects.
REQ-011 aluop  out  alu_ops  ALU operation.
REQ-012 cmpop  out  branch_funct3_t  comparator operation.
REQ-013 mem_read, mem_write  out  1  memory strobes, held until mem_resp.
REQ-014 mem_byte_enable  out  4  write byte mask.

Function
REQ-015 Moore FSM; every output is a function of state plus IR fields and addr_lo only, never of mem_resp.
REQ-016 Default every cycle: all loads 0, strobes 0, byte_enable 4'b1111, pcmux pc_plus4, alumux1 rs1_out, alumux2 i_imm, regfilemux alu_out, marmux pc_out, cmpmux rs2_out, aluop add, cmpop = funct3.
REQ-017 States: FETCH1, FETCH2, FETCH3, DECODE, IMM, REG, LUI, AUIPC, BR, JAL, JALR, CALC_ADDR, LD1, LD2, ST1, ST2.
REQ-018 FETCH1: load_mar, marmux pc_out -> FETCH2.
REQ-019 FETCH2: mem_read, load_mdr; remain until mem_resp=1, then -> FETCH3.
REQ-020 FETCH3: load_ir -> DECODE; DECODE selects the state by opcode; unknown opcode -> FETCH1 with no register or PC write.
REQ-021 IMM: slti/sltiu use cmpmux i_imm, regfilemux br_en; srai uses aluop sra when funct7[5]=1; other ops use aluop = funct3; load_regfile, load_pc -> FETCH1.
REQ-022 REG: alumux2 rs2_out; add/sub and srl/sra are chosen by funct7[5]; slt/sltu go through cmp with rs2_out; load_regfile, load_pc -> FETCH1.
REQ-023 LUI: regfilemux u_imm. AUIPC: alumux1 pc_out, alumux2 u_imm. Both assert load_regfile and load_pc, then -> FETCH1.
REQ-024 BR: alumux1 pc_out, alumux2 b_imm, load_pc; pcmux alu_out if br_en else pc_plus4 -> FETCH1.
REQ-025 JAL: regfilemux pc_plus4, alumux1 pc_out, alumux2 j_imm, pcmux alu_out, load_regfile, load_pc. JALR: same with alumux1 rs1_out, alumux2 i_imm, pcmux alu_mod2. Both -> FETCH1.
REQ-026 CALC_ADDR: marmux alu_out, load_mar; alumux2 s_imm for store (also load_data_out) or i_imm for load -> ST1 or LD1.
REQ-027 LD1: mem_read, load_mdr until mem_resp -> LD2. LD2: regfilemux per funct3 (lb/lh/lw/lbu/lhu), aluop add with i_imm, load_regfile, load_pc -> FETCH1.
REQ-028 ST1: mem_write, alumux2 s_imm; byte_enable is 4'b0001<<addr_lo for sb, 4'b0011<<addr_lo for sh, 4'b1111 for sw. Remain until mem_resp -> ST2. ST2: load_pc -> FETCH1.
REQ-029 mem_resp arriving outside FETCH2, LD1 or ST1 shall be ignored.
REQ-030 sh with addr_lo=2'b11 shall still issue mask 4'b1000 (truncated to 4 bits); misalignment is not trapped.

Reset
REQ-031 rst=0 forces FETCH1 asynchronously; all outputs take the REQ-016 defaults immediately, including a strobe held mid-transaction.
REQ-032 After rst returns to 1, the first rising edge executes FETCH1.

Structure
REQ-033 State enum mc_state_t belongs in rv32i_types; the mux enums remain in the existing mux packages.
REQ-034 Single module with no sub-module: a state register block, a next-state comb block and an output comb block.

Verification
REQ-035 addi x1,x0,5 with mem_resp after 3 wait cycles -> FETCH2 held 4 cycles; IMM asserts load_regfile and load_pc; PC+4 afterwards.
REQ-036 beq with br_en=1, b_imm=-8 -> BR selects pcmux alu_out; PC=0x60 becomes 0x58.
REQ-037 sb at address 0x103 with rs2=0xAB -> ST1 mem_write with byte_enable 4'b1000 until mem_resp.
REQ-038 lhu at address 0x102 -> LD1 then LD2 with regfilemux lhu and load_regfile=1 exactly one cycle.
REQ-039 rst=0 during LD1 with mem_read=1 -> mem_read drops in the same cycle; the state is FETCH1 at the next edge after release.
REQ-040 Opcode 7'b0000000 -> DECODE goes to FETCH1; load_regfile and load_pc are never asserted.
